// File: rtl/heart_rate_calc.sv
// heart_rate_calc
//   Heartbeat detector and BPM calculator for filtered PPG samples.
//   A hysteretic peak/trough tracker finds candidate peaks; peaks at least
//   REFRACT samples after the previous beat become beats. The last four
//   beat-to-beat intervals are summed and 60*SAMPLE_RATE_HZ*4 is divided by
//   that sum with a 24-step restoring divider to give BPM (saturated to 255).
//   TIMEOUT samples without a beat declare the signal lost.
//
// Ports
//   clk          : rising-edge clock
//   reset        : synchronous, active-low
//   sample_valid : one-cycle strobe qualifying sample
//   sample       : filtered sample, unsigned DATA_W bits
//   beat         : one-cycle pulse per accepted heartbeat
//   bpm          : latest rate in BPM, 0 while no signal
//   bpm_valid    : one-cycle pulse when bpm is loaded by the divider
//   no_signal    : high while no valid rate is available
//
// Handshake: sample_valid is a pure strobe with no back-pressure; every cycle
// it is high, sample is consumed. There is no ready signal.
module heart_rate_calc #(
  parameter int DATA_W         = 10,
  parameter int SAMPLE_RATE_HZ = 100,
  parameter int HYST           = 8,
  parameter int REFRACT        = 30,
  parameter int TIMEOUT        = 300
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              beat,
  output logic [7:0]        bpm,
  output logic              bpm_valid,
  output logic              no_signal
);

  // icnt saturates at TIMEOUT, so n = icnt + 1 can reach TIMEOUT + 1.
  localparam int ICNT_W = $clog2(TIMEOUT + 2);
  localparam int SUM_W  = 12;
  localparam int Q_W    = 24;
  localparam logic [Q_W-1:0]    DIVIDEND  = Q_W'(60 * SAMPLE_RATE_HZ * 4);
  localparam logic [ICNT_W-1:0] TIMEOUT_C = ICNT_W'(TIMEOUT);
  localparam logic [ICNT_W-1:0] REFRACT_C = ICNT_W'(REFRACT);
  localparam logic [DATA_W:0]   HYST_C    = (DATA_W + 1)'(HYST);
  localparam logic [4:0]        LAST_STEP = 5'(Q_W - 1);

  typedef enum logic {RISING = 1'b0, FALLING = 1'b1} det_state_t;
  typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, DONE = 2'd2} div_state_t;

  // ---------------- detector ----------------
  det_state_t        det_state, det_state_d;
  logic [DATA_W-1:0] pk_max, pk_max_d, pk_min, pk_min_d;
  logic [DATA_W:0]   sample_x, pk_max_x, pk_min_x;
  logic [ICNT_W-1:0] icnt, n;
  logic              peak_hit, trough_hit, is_beat, is_timeout;

  // One extra bit on every comparison so sample + HYST cannot wrap.
  assign sample_x   = {1'b0, sample};
  assign pk_max_x   = {1'b0, pk_max};
  assign pk_min_x   = {1'b0, pk_min};
  assign n          = icnt + ICNT_W'(1);
  assign peak_hit   = (det_state == RISING)  && (sample_x + HYST_C <= pk_max_x);
  assign trough_hit = (det_state == FALLING) && (sample_x >= pk_min_x + HYST_C);
  assign is_beat    = sample_valid && peak_hit && (n >= REFRACT_C);
  // A beat clears icnt, so it takes precedence over a coincident timeout.
  assign is_timeout = sample_valid && !is_beat && (n == TIMEOUT_C);

  always_ff @(posedge clk) begin
    if (!reset) begin
      det_state <= RISING;
      pk_max    <= '0;
      pk_min    <= '0;
    end else begin
      det_state <= det_state_d;
      pk_max    <= pk_max_d;
      pk_min    <= pk_min_d;
    end
  end

  always_comb begin
    det_state_d = det_state;
    pk_max_d    = pk_max;
    pk_min_d    = pk_min;
    if (sample_valid) begin
      if (is_timeout) begin
        det_state_d = RISING;
        pk_max_d    = sample;
      end else if (det_state == RISING) begin
        if (peak_hit) begin
          pk_min_d    = sample;
          det_state_d = FALLING;
        end else if (sample > pk_max) begin
          pk_max_d = sample;
        end
      end else begin
        if (trough_hit) begin
          pk_max_d    = sample;
          det_state_d = RISING;
        end else if (sample < pk_min) begin
          pk_min_d = sample;
        end
      end
    end
  end

  // ---------------- interval history ----------------
  logic [ICNT_W-1:0] hist [4];   // hist[0] is the newest interval
  logic [2:0]        hcount;
  logic              have_ref, div_req, pending;
  logic [SUM_W-1:0]  div_sum, push_sum;

  // Sum of the history as it will be after pushing n.
  assign push_sum = SUM_W'(hist[0]) + SUM_W'(hist[1]) + SUM_W'(hist[2]) + SUM_W'(n);

  // ---------------- divider ----------------
  div_state_t       div_state, div_state_d;
  logic [SUM_W-1:0] divisor, rem, rem_next;
  logic [SUM_W:0]   rem_sh;
  logic [Q_W-1:0]   quo, quo_next;
  logic [4:0]       step;
  logic             q_bit, div_start, div_finish;
  logic [7:0]       bpm_sat;

  // quo starts as the dividend; each step shifts its MSB into the partial
  // remainder and the new quotient bit into its LSB.
  assign rem_sh     = {rem, quo[Q_W-1]};
  assign q_bit      = rem_sh >= {1'b0, divisor};
  assign rem_next   = q_bit ? SUM_W'(rem_sh - {1'b0, divisor}) : rem_sh[SUM_W-1:0];
  assign quo_next   = {quo[Q_W-2:0], q_bit};
  assign div_finish = (div_state == DIVIDE) && (step == LAST_STEP) && !is_timeout;
  assign bpm_sat    = (|quo_next[Q_W-1:8]) ? 8'hFF : quo_next[7:0];
  assign bpm_valid  = (div_state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) div_state <= IDLE;
    else        div_state <= div_state_d;
  end

  always_comb begin
    div_state_d = div_state;
    div_start   = 1'b0;
    case (div_state)
      IDLE: begin
        if (div_req || pending) begin
          div_state_d = DIVIDE;
          div_start   = 1'b1;
        end
      end
      DIVIDE:  if (step == LAST_STEP) div_state_d = DONE;
      DONE:    div_state_d = IDLE;
      default: div_state_d = IDLE;
    endcase
    // Loss of signal aborts any divide in flight.
    if (is_timeout) begin
      div_state_d = IDLE;
      div_start   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      step    <= '0;
    end else if (div_start) begin
      divisor <= div_sum;
      rem     <= '0;
      quo     <= DIVIDEND;
      step    <= '0;
    end else if (div_state == DIVIDE) begin
      rem  <= rem_next;
      quo  <= quo_next;
      step <= step + 5'd1;
    end
  end

  // ---------------- counters, history and outputs ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      icnt      <= '0;
      hist[0]   <= '0;
      hist[1]   <= '0;
      hist[2]   <= '0;
      hist[3]   <= '0;
      hcount    <= '0;
      have_ref  <= 1'b0;
      div_sum   <= '0;
      div_req   <= 1'b0;
      pending   <= 1'b0;
      beat      <= 1'b0;
      bpm       <= '0;
      no_signal <= 1'b1;
    end else begin
      beat    <= 1'b0;
      div_req <= 1'b0;

      if (sample_valid) begin
        if (is_beat)           icnt <= '0;
        else if (n > TIMEOUT_C) icnt <= TIMEOUT_C;
        else                   icnt <= n;
      end

      if (is_beat) begin
        beat <= 1'b1;
        if (!have_ref) begin
          // First beat only establishes the reference point.
          have_ref <= 1'b1;
        end else begin
          hist[0] <= n;
          hist[1] <= hist[0];
          hist[2] <= hist[1];
          hist[3] <= hist[2];
          div_sum <= push_sum;
          if (hcount != 3'd4) hcount <= hcount + 3'd1;
          div_req <= (hcount >= 3'd3);
        end
      end

      if (is_timeout) begin
        have_ref <= 1'b0;
        hcount   <= '0;
        hist[0]  <= '0;
        hist[1]  <= '0;
        hist[2]  <= '0;
        hist[3]  <= '0;
        div_sum  <= '0;
      end

      // A request that arrives while the divider is busy is remembered once.
      if (is_timeout || div_start)          pending <= 1'b0;
      else if (div_req && div_state != IDLE) pending <= 1'b1;

      if (is_timeout) begin
        no_signal <= 1'b1;
        bpm       <= '0;
      end else if (div_finish) begin
        no_signal <= 1'b0;
        bpm       <= bpm_sat;
      end
    end
  end

endmodule

// File: tb/tb_heart_rate_calc.sv
// tb_heart_rate_calc
//   Bench for heart_rate_calc. Two instances: u_dut0 with default
//   parameters and u_dut1 with HYST=4, REFRACT=10; sel picks which one is
//   driven and observed. Each sample is followed by 31 idle clocks and the
//   whole window is checked against a per-sample behavioural model.
module tb_heart_rate_calc;

  localparam int TIMEOUT  = 300;
  localparam int DIVIDEND = 24000;
  localparam int SPACING  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       sv0 = 1'b0, sv1 = 1'b0, sel = 1'b0;
  logic [9:0] sample = '0;
  logic       beat0, beat1, bv0, bv1, ns0, ns1;
  logic [7:0] bpm0, bpm1;
  logic       beat, bpm_valid, no_signal;
  logic [7:0] bpm;

  assign beat      = sel ? beat1 : beat0;
  assign bpm_valid = sel ? bv1   : bv0;
  assign no_signal = sel ? ns1   : ns0;
  assign bpm       = sel ? bpm1  : bpm0;

  heart_rate_calc u_dut0 (
    .clk(clk), .reset(reset), .sample_valid(sv0), .sample(sample),
    .beat(beat0), .bpm(bpm0), .bpm_valid(bv0), .no_signal(ns0)
  );

  heart_rate_calc #(.HYST(4), .REFRACT(10)) u_dut1 (
    .clk(clk), .reset(reset), .sample_valid(sv1), .sample(sample),
    .beat(beat1), .bpm(bpm1), .bpm_valid(bv1), .no_signal(ns1)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int obs_beats = 0;
  int obs_valids = 0;
  bit arm_reset = 1'b0;
  int rip [12] = '{0, 1, 2, 3, 4, 5, 5, 4, 3, 2, 1, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (one call per sample) ----------------
  int  m_hyst, m_refract;
  bit  m_rising, m_have_ref, m_ns, m_beat, m_div, m_to;
  int  m_pk_max, m_pk_min, m_icnt, m_bpm;
  int  hist_q[$];

  task automatic model_reset();
    m_rising = 1; m_pk_max = 0; m_pk_min = 0; m_icnt = 0;
    m_have_ref = 0; hist_q.delete(); m_ns = 1; m_bpm = 0;
  endtask

  task automatic model_step(input int s);
    int n, sum, q;
    bit peak;
    n = m_icnt + 1;
    peak = m_rising && (s + m_hyst <= m_pk_max);
    m_beat = peak && (n >= m_refract);
    m_to = !m_beat && (n == TIMEOUT);
    m_div = 0;
    if (m_to) begin
      m_rising = 1; m_pk_max = s; m_icnt = TIMEOUT;
      m_have_ref = 0; hist_q.delete(); m_ns = 1; m_bpm = 0;
    end else begin
      if (m_rising) begin
        if (peak) begin m_pk_min = s; m_rising = 0; end
        else if (s > m_pk_max) m_pk_max = s;
      end else begin
        if (s >= m_pk_min + m_hyst) begin m_pk_max = s; m_rising = 1; end
        else if (s < m_pk_min) m_pk_min = s;
      end
      if (m_beat) begin
        m_icnt = 0;
        if (!m_have_ref) m_have_ref = 1;
        else begin
          hist_q.push_back(n);
          if (hist_q.size() > 4) void'(hist_q.pop_front());
          if (hist_q.size() == 4) begin
            sum = hist_q.sum();
            q = DIVIDEND / sum;
            m_bpm = (q > 255) ? 255 : q;
            m_ns = 0;
            m_div = 1;
            exp_q.push_back(8'(m_bpm));
          end
        end
      end else begin
        m_icnt = (n > TIMEOUT) ? TIMEOUT : n;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; sv0 = 1'b0; sv1 = 1'b0;
    @(negedge clk);
    check("rst_beat", beat, 0);
    check("rst_bpm", bpm, 0);
    check("rst_bpm_valid", bpm_valid, 0);
    check("rst_no_signal", no_signal, 1);
    reset = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  task automatic send(input int s);
    int vcount, vk, bcount, rst_k;
    bit exp_div;
    vcount = 0; vk = 0; bcount = 0;
    @(negedge clk);
    sample = 10'(s);
    if (sel) sv1 = 1'b1; else sv0 = 1'b1;
    model_step(s);
    exp_div = m_div;
    rst_k = 0;
    if (arm_reset && m_div) begin rst_k = 10; arm_reset = 1'b0; end
    for (int k = 1; k < SPACING; k++) begin
      @(negedge clk);
      if (k == 1) begin
        sv0 = 1'b0; sv1 = 1'b0;
        check("beat", beat, m_beat);
        if (m_to) begin
          check("timeout_no_signal", no_signal, 1);
          check("timeout_bpm", bpm, 0);
        end
      end
      if (beat) begin bcount++; obs_beats++; end
      if (bpm_valid) begin
        vcount++; vk = k; obs_valids++;
        if (exp_q.size() == 0) check("bpm_valid_unexpected", 1, 0);
        else check("bpm", bpm, exp_q.pop_front());
      end
      if (rst_k != 0 && k == rst_k) reset = 1'b0;
      if (rst_k != 0 && k == rst_k + 1) begin
        check("midrst_beat", beat, 0);
        check("midrst_bpm", bpm, 0);
        check("midrst_bpm_valid", bpm_valid, 0);
        check("midrst_no_signal", no_signal, 1);
        reset = 1'b1;
        model_reset();
        exp_q.delete();
        exp_div = 0;
      end
    end
    check("beat_count", bcount, m_beat);
    check("bpm_valid_count", vcount, exp_div);
    if (exp_div) check("bpm_valid_latency", vk, 26);
    check("bpm_level", bpm, m_bpm);
    check("no_signal_level", no_signal, m_ns);
  endtask

  function automatic int tri_val(input int p, input int period, input int lo, input int hi);
    int rise;
    rise = period / 2;
    if (p <= rise) return lo + p * (hi - lo) / rise;
    return hi - (p - rise) * (hi - lo) / (period - rise);
  endfunction

  // bump adds a 20-LSB secondary peak shortly after the beat (period 75,
  // 100..400 waveform only).
  task automatic run_tri(input int periods, input int period, input int lo,
                         input int hi, input int noise, input bit bump);
    int v;
    for (int c = 0; c < periods; c++) begin
      for (int p = 0; p < period; p++) begin
        v = tri_val(p, period, lo, hi);
        if (bump && p == 46) v = 350;
        if (bump && p == 47) v = 370;
        if (bump && p == 48) v = 350;
        if (noise > 0) v += $urandom_range(0, noise);
        if (v > 1023) v = 1023;
        send(v);
      end
    end
  endtask

  task automatic run_ripple(input int count);
    for (int i = 0; i < count; i++) send(250 + rip[i % 12]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b0, v0, per, lo, hi;
    m_hyst = 8; m_refract = 30;
    model_reset();
    do_reset();

    // steady rhythm: 75-sample period -> 24000/300 = 80 BPM
    run_tri(6, 75, 100, 400, 0, 0);
    check("steady_bpm", bpm, 80);
    check("steady_no_signal", no_signal, 0);

    // refractory: secondary peak is ignored, intervals stay 75
    b0 = obs_beats;
    run_tri(1, 75, 100, 400, 0, 1);
    run_tri(1, 75, 100, 400, 0, 0);
    check("refract_beats", obs_beats - b0, 2);
    check("refract_bpm", bpm, 80);

    // hysteresis: 5-LSB ripple never beats with HYST=8
    b0 = obs_beats;
    run_ripple(100);
    check("hyst8_beats", obs_beats - b0, 0);

    // timeout: flat input well past TIMEOUT samples since the last beat
    for (int i = 0; i < 200; i++) send(250);
    check("lost_no_signal", no_signal, 1);
    check("lost_bpm", bpm, 0);

    // recovery
    run_tri(5, 75, 100, 400, 0, 0);
    check("recovery_bpm", bpm, 80);
    check("recovery_no_signal", no_signal, 0);

    // reset at S+10 of a divide; afterwards the first beat gives no bpm_valid
    arm_reset = 1'b1;
    run_tri(1, 75, 100, 400, 0, 0);
    check("midrst_done", arm_reset, 0);
    v0 = obs_valids;
    run_tri(2, 75, 100, 400, 0, 0);
    check("post_reset_valids", obs_valids - v0, 0);

    // randomized waveforms
    for (int r = 0; r < 3; r++) begin
      per = $urandom_range(40, 90);
      lo  = $urandom_range(50, 300);
      hi  = lo + $urandom_range(100, 400);
      run_tri(1, per, lo, hi, 2, 0);
    end

    // second instance: HYST=4, REFRACT=10
    sel = 1'b1;
    m_hyst = 4; m_refract = 10;
    do_reset();
    b0 = obs_beats;
    run_ripple(100);
    check("hyst4_beats", (obs_beats - b0) > 0, 1);

    // saturation: 20-sample period -> quotient 300 -> 255
    do_reset();
    run_tri(6, 20, 100, 400, 0, 0);
    check("saturate_bpm", bpm, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
